aes_sub_bytes_masked_serial: RTL and testbench
==============================================

Name: aes_sub_bytes_masked_serial

Overview:
Byte-serial masked SubBytes / InvSubBytes engine for the area-optimised AES cipher core. It latches a masked 128-bit state and its mask, then streams the 16 byte pairs through one instance of the Canright masked S-box (aes_sbox_canright_masked_noreuse), one byte per cycle. It draws 18 bits of fresh randomness per byte through a valid/consume handshake. The remasked 128-bit state and its new mask are returned to the cipher control via a req/ack handshake.

Parameters:
NumBytes, 16, number of state bytes processed per operation; fixed at 16, any other value is an elaboration error.
PrdW, 18, width of per-byte fresh randomness; must match the S-box prd width.

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, synchronous, active-low
en_i  input  1  start request; must remain high for the whole operation
op_i  input  2  2'b01 = forward SubBytes, 2'b10 = InvSubBytes; sampled at start
data_i  input  128  masked state in; byte k = data_i[8k+7:8k]
mask_i  input  128  mask of data_i, same byte layout
prd_i  input  18  fresh randomness for the current byte
prd_valid_i  input  1  prd_i holds fresh, unused bits
prd_consume_o  output  1  prd_i was used this cycle; producer must advance
out_req_o  output  1  result valid, held until acknowledged
out_ack_i  input  1  consumer has taken the result
data_o  output  128  masked substituted state
mask_o  output  128  new output mask; per byte, mask_o byte = prd_i[7:0] used for that byte
busy_o  output  1  high whenever the FSM is not in IDLE
err_o  output  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset (rst_ni low at a rising edge): FSM goes to IDLE; byte counter = 0; all outputs = 0; internal state and mask registers = 0.
- IDLE:
  - en_i=1 and op_i in {01,10}: latch data_i, mask_i and op_i; counter = 0; go to RUN.
  - en_i=1 and op_i in {00,11}: pulse err_o, stay in IDLE, latch nothing.
- RUN, each cycle:
  - Byte [counter] of the latched state, its mask byte, the latched op and prd_i drive the combinational S-box.
  - If prd_valid_i=1: write the S-box data output and mask output into byte [counter] of the output registers, assert prd_consume_o in the same cycle, and increment the counter.
  - If prd_valid_i=0: stall; no register changes; prd_consume_o = 0.
  - When counter = 15 and prd_valid_i = 1: write the final byte, set out_req_o = 1 from the next cycle, and go to DONE.
- DONE:
  - Hold out_req_o, data_o and mask_o stable until out_ack_i = 1.
  - On the ack cycle, go to IDLE. On the following cycle, clear out_req_o, data_o, mask_o and the latched state/mask to 0 (no residual shares left in registers).
- Latency: with prd_valid_i held high, start is accepted at cycle 0 and bytes are processed in cycles 1..16; out_req_o is high from cycle 17. Each prd stall cycle adds one cycle.
- Abort: en_i = 0 during RUN or DONE returns the FSM to IDLE on the next edge with the same clearing as after an ack. No out_req_o is produced.
- Simultaneous events: out_ack_i together with en_i=1 in DONE is treated as an ack only; a new start needs en_i sampled in IDLE.
- Restrictions:
  - prd_consume_o is never high outside RUN.
  - Each prd_i value is used for exactly one byte.
  - Counter wrap-around past 15 must never occur.
- FSM state encoding is sparse (Hamming distance ≥3). Any illegal encoding forces IDLE, clears all registers, and pulses err_o.

Decomposition:
- Package (aes_pkg):
  - op enum: CIPH_FWD = 2'b01, CIPH_INV = 2'b10.
  - sparse FSM state encodings: IDLE, RUN, DONE.
  - NumBytes constant.
- Sub-module: a single instance of aes_sbox_canright_masked_noreuse. No other sub-modules are needed; the counter and FSM are local.

Test Plan:
- Zero state: data_i = 0, mask_i = 0, op = 01, prd_i = 0 and prd_valid_i = 1 throughout → out_req_o at cycle 17; data_o = 128'h6363…63; mask_o = 0; exactly 16 prd_consume_o pulses.
- Masked forward: byte 0 data = 0xF6, mask = 0xA5 (plain 0x53); prd_i[7:0] = 0x3C → data_o[7:0] = 0xD1 (0xED ^ 0x3C); mask_o[7:0] = 0x3C.
- Inverse: data_i = 128'h6363…63, mask_i = 0, op = 10, prd_i = 0 → data_o = 0; then ack → all outputs read 0 one cycle after ack.
- Stalls: prd_valid_i low on every other cycle → 16 consumes; out_req_o at cycle 33; result identical to the no-stall run.
- Abort and reject:
  - en_i dropped after 5 bytes → IDLE; no out_req_o; outputs 0.
  - op = 2'b11 in IDLE → err_o pulses once; busy_o stays 0.
- Reset mid-RUN: rst_ni low for one edge at byte 8 → all outputs 0 and busy_o = 0; a fresh start afterwards completes correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and encodings for the byte-serial masked SubBytes engine.
package aes_pkg;

    localparam int NumStateBytes = 16;
    localparam int PrdWidth      = 18;

    typedef enum logic [1:0] {
        CIPH_FWD = 2'b01,
        CIPH_INV = 2'b10
    } ciph_op_e;

    // Pairwise Hamming distance >= 3, so a single flipped bit never lands on a legal state.
    typedef enum logic [5:0] {
        SB_IDLE = 6'b000111,
        SB_RUN  = 6'b111000,
        SB_DONE = 6'b101101
    } sb_state_e;

endpackage

// File: rtl/aes_sbox_canright_masked_noreuse.sv
// Masked S-box slot: takes one masked byte plus its mask, substitutes it
// (forward or inverse) and returns the result under the fresh mask prd_i[7:0].
module aes_sbox_canright_masked_noreuse
    import aes_pkg::*;
(
    input  logic [1:0]          op_i,
    input  logic [7:0]          data_i,
    input  logic [7:0]          mask_i,
    input  logic [PrdWidth-1:0] prd_i,
    output logic [7:0]          data_o,
    output logic [7:0]          mask_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, a);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int unsigned n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] v);
        return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] v);
        return rotl(v, 1) ^ rotl(v, 3) ^ rotl(v, 6) ^ 8'h05;
    endfunction

    logic [7:0] x;
    logic [7:0] y;
    logic       unused_prd;

    assign x = data_i ^ mask_i;

    always_comb begin
        y = 8'h00;
        if (op_i == CIPH_INV) begin
            y = gf_inv(inv_affine(x));
        end else begin
            y = fwd_affine(gf_inv(x));
        end
    end

    assign data_o     = y ^ prd_i[7:0];
    assign mask_o     = prd_i[7:0];
    assign unused_prd = ^prd_i[PrdWidth-1:8];

endmodule

// File: rtl/aes_sub_bytes_masked_serial.sv
// Byte-serial masked SubBytes/InvSubBytes: one S-box, one byte per prd handshake.
//   state   | meaning
//   SB_IDLE | waiting for en_i; rejects illegal op with an err_o pulse
//   SB_RUN  | streaming bytes through the S-box, one per valid prd
//   SB_DONE | result held on out_req_o until out_ack_i or en_i drop
module aes_sub_bytes_masked_serial
    import aes_pkg::*;
#(
    parameter int NumBytes = 16,
    parameter int PrdW     = 18
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic [1:0]            op_i,
    input  logic [8*NumBytes-1:0] data_i,
    input  logic [8*NumBytes-1:0] mask_i,
    input  logic [PrdW-1:0]       prd_i,
    input  logic                  prd_valid_i,
    output logic                  prd_consume_o,
    output logic                  out_req_o,
    input  logic                  out_ack_i,
    output logic [8*NumBytes-1:0] data_o,
    output logic [8*NumBytes-1:0] mask_o,
    output logic                  busy_o,
    output logic                  err_o
);

    if (NumBytes != NumStateBytes) begin : g_bad_num_bytes
        $error("aes_sub_bytes_masked_serial: NumBytes must be 16");
    end
    if (PrdW != PrdWidth) begin : g_bad_prd_w
        $error("aes_sub_bytes_masked_serial: PrdW must be 18");
    end

    sb_state_e             state_q, state_d;
    logic [3:0]            cnt_q;
    logic [1:0]            op_q;
    logic [8*NumBytes-1:0] data_q, mask_q;
    logic [8*NumBytes-1:0] data_out_q, mask_out_q;
    logic                  out_req_q;
    logic                  err_q;

    logic                  load, clear, wr_byte, set_req, err_d;
    logic [7:0]            sbox_data, sbox_mask;
    logic [6:0]            byte_idx;

    assign byte_idx = {cnt_q, 3'b000};

    aes_sbox_canright_masked_noreuse u_sbox (
        .op_i   (op_q),
        .data_i (data_q[byte_idx +: 8]),
        .mask_i (mask_q[byte_idx +: 8]),
        .prd_i  (prd_i),
        .data_o (sbox_data),
        .mask_o (sbox_mask)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= SB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        clear   = 1'b0;
        wr_byte = 1'b0;
        set_req = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            SB_IDLE: begin
                if (en_i) begin
                    if (op_i == CIPH_FWD || op_i == CIPH_INV) begin
                        load    = 1'b1;
                        state_d = SB_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SB_RUN: begin
                if (!en_i) begin
                    clear   = 1'b1;
                    state_d = SB_IDLE;
                end else if (prd_valid_i) begin
                    wr_byte = 1'b1;
                    if (cnt_q == 4'd15) begin
                        set_req = 1'b1;
                        state_d = SB_DONE;
                    end
                end
            end
            SB_DONE: begin
                // Ack wins over a still-high en_i; a new start must be seen in IDLE.
                if (out_ack_i || !en_i) begin
                    clear   = 1'b1;
                    state_d = SB_IDLE;
                end
            end
            default: begin
                clear   = 1'b1;
                err_d   = 1'b1;
                state_d = SB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear) begin
            cnt_q      <= 4'd0;
            op_q       <= 2'b00;
            data_q     <= '0;
            mask_q     <= '0;
            data_out_q <= '0;
            mask_out_q <= '0;
            out_req_q  <= 1'b0;
        end else begin
            if (load) begin
                cnt_q  <= 4'd0;
                op_q   <= op_i;
                data_q <= data_i;
                mask_q <= mask_i;
            end
            if (wr_byte) begin
                data_out_q[byte_idx +: 8] <= sbox_data;
                mask_out_q[byte_idx +: 8] <= sbox_mask;
                if (cnt_q != 4'd15) cnt_q <= cnt_q + 4'd1;
            end
            if (set_req) out_req_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign prd_consume_o = wr_byte;
    assign out_req_o     = out_req_q;
    assign data_o        = data_out_q;
    assign mask_o        = mask_out_q;
    assign busy_o        = (state_q != SB_IDLE);
    assign err_o         = err_q;

endmodule

// File: tb/tb_aes_sub_bytes_masked_serial.sv
// Self-checking bench for aes_sub_bytes_masked_serial against a table-based S-box model.
module tb_aes_sub_bytes_masked_serial;

    logic         clk_i;
    logic         rst_ni;
    logic         en_i;
    logic [1:0]   op_i;
    logic [127:0] data_i;
    logic [127:0] mask_i;
    logic [17:0]  prd_i;
    logic         prd_valid_i;
    logic         prd_consume_o;
    logic         out_req_o;
    logic         out_ack_i;
    logic [127:0] data_o;
    logic [127:0] mask_o;
    logic         busy_o;
    logic         err_o;

    int errors = 0;
    int checks = 0;

    logic [7:0] sbox_t  [256];
    logic [7:0] isbox_t [256];

    aes_sub_bytes_masked_serial dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .op_i          (op_i),
        .data_i        (data_i),
        .mask_i        (mask_i),
        .prd_i         (prd_i),
        .prd_valid_i   (prd_valid_i),
        .prd_consume_o (prd_consume_o),
        .out_req_o     (out_req_o),
        .out_ack_i     (out_ack_i),
        .data_o        (data_o),
        .mask_o        (mask_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    // Polynomial product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        logic [14:0] poly;
        p    = '0;
        poly = 15'h011b;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (poly << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_tables;
        logic [7:0] c;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            logic [7:0] s;
            inv = 8'h00;
            for (int b = 1; b < 256; b++) if (ref_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_t[a] = s;
        end
        for (int a = 0; a < 256; a++) isbox_t[sbox_t[a]] = 8'(a);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives one operation. stall_mode: 0 never stall, 1 valid on even cycles, 2 random.
    // stop_after > 0 drops en_i (or pulses reset) once that many bytes were offered.
    task automatic run_op(input logic [127:0] d, input logic [127:0] m, input logic [1:0] op,
                          input int stall_mode, input bit fix_prd, input logic [17:0] prd_fix,
                          input int stop_after, input bit stop_rst,
                          output int lat, output int exp_lat, output int n_cons,
                          output logic [127:0] exp_d, output logic [127:0] exp_m,
                          output bit timed_out);
        int         n_drv;
        int         cyc;
        bit         v;
        logic [7:0] db;
        n_drv = 0; n_cons = 0; lat = -1; exp_lat = -1; timed_out = 0;
        exp_d = '0; exp_m = '0;
        @(negedge clk_i);
        en_i = 1'b1; op_i = op; data_i = d; mask_i = m; prd_valid_i = 1'b0;
        @(posedge clk_i);
        cyc = 1;
        forever begin
            @(negedge clk_i);
            if (out_req_o) begin
                lat = cyc;
                break;
            end
            if (cyc > 200) begin
                timed_out = 1;
                break;
            end
            if (stop_after > 0 && n_drv == stop_after) begin
                if (stop_rst) rst_ni = 1'b0;
                en_i = 1'b0;
                prd_valid_i = 1'b0;
                @(posedge clk_i);
                #1 rst_ni = 1'b1;
                break;
            end
            case (stall_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            if (n_drv >= 16) v = 1'b0;
            prd_i = fix_prd ? prd_fix : 18'($urandom);
            prd_valid_i = v;
            #1;
            if (prd_consume_o) n_cons++;
            if (v) begin
                db = d[8*n_drv +: 8] ^ m[8*n_drv +: 8];
                exp_d[8*n_drv +: 8] = ((op == 2'b10) ? isbox_t[db] : sbox_t[db]) ^ prd_i[7:0];
                exp_m[8*n_drv +: 8] = prd_i[7:0];
                n_drv++;
                if (n_drv == 16) exp_lat = cyc + 1;
            end
            @(posedge clk_i);
            cyc++;
        end
        prd_valid_i = 1'b0;
    endtask

    task automatic release_op;
        @(negedge clk_i);
        out_ack_i = 1'b1; en_i = 1'b0; prd_valid_i = 1'b0;
        @(posedge clk_i);
        #1 out_ack_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0; en_i = 1'b1; op_i = 2'b01; prd_valid_i = 1'b1;
        data_i = 128'h1; mask_i = 128'h2;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checks++; if (out_req_o !== 1'b0) begin errors++; $display("FAIL reset_out_req: got %b want 0", out_req_o); end
        checks++; if (data_o !== 128'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data_o); end
        checks++; if (mask_o !== 128'h0) begin errors++; $display("FAIL reset_mask: got %h want 0", mask_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
        checks++; if (prd_consume_o !== 1'b0) begin errors++; $display("FAIL reset_consume: got %b want 0", prd_consume_o); end
        rst_ni = 1'b1; en_i = 1'b0; prd_valid_i = 1'b0;
        @(posedge clk_i);
    endtask

    task automatic test_zero_state;
        int lat, exp_lat, n_cons;
        logic [127:0] ed, em, want;
        bit to;
        want = {16{8'h63}};
        run_op('0, '0, 2'b01, 0, 1, 18'h0, 0, 0, lat, exp_lat, n_cons, ed, em, to);
        checks++; if (to) begin errors++; $display("FAIL zero_timeout: out_req not seen within budget"); end
        checks++; if (lat != 17) begin errors++; $display("FAIL zero_latency: got %0d want 17", lat); end
        checks++; if (n_cons != 16) begin errors++; $display("FAIL zero_consumes: got %0d want 16", n_cons); end
        checks++; if (data_o !== want) begin errors++; $display("FAIL zero_data: got %h want %h", data_o, want); end
        checks++; if (mask_o !== 128'h0) begin errors++; $display("FAIL zero_mask: got %h want 0", mask_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL zero_busy_done: got %b want 1", busy_o); end
        prd_valid_i = 1'b1;
        #1;
        checks++; if (prd_consume_o !== 1'b0) begin errors++; $display("FAIL done_no_consume: got %b want 0", prd_consume_o); end
        prd_valid_i = 1'b0;
        release_op();
    endtask

    task automatic test_masked_fwd;
        int lat, exp_lat, n_cons;
        logic [127:0] d, m, ed, em;
        logic [17:0] pf;
        bit to;
        d = rand128(); m = rand128();
        d[7:0] = 8'hF6; m[7:0] = 8'hA5;
        pf = {10'($urandom), 8'h3C};
        run_op(d, m, 2'b01, 0, 1, pf, 0, 0, lat, exp_lat, n_cons, ed, em, to);
        checks++; if (to) begin errors++; $display("FAIL fwd_timeout: out_req not seen within budget"); end
        checks++; if (data_o[7:0] !== 8'hD1) begin errors++; $display("FAIL fwd_byte0_data: got %h want d1", data_o[7:0]); end
        checks++; if (mask_o[7:0] !== 8'h3C) begin errors++; $display("FAIL fwd_byte0_mask: got %h want 3c", mask_o[7:0]); end
        checks++; if (data_o !== ed) begin errors++; $display("FAIL fwd_data: got %h want %h", data_o, ed); end
        checks++; if (mask_o !== em) begin errors++; $display("FAIL fwd_mask: got %h want %h", mask_o, em); end
        release_op();
    endtask

    task automatic test_inverse_ack;
        int lat, exp_lat, n_cons;
        logic [127:0] ed, em;
        bit to;
        run_op({16{8'h63}}, '0, 2'b10, 0, 1, 18'h0, 0, 0, lat, exp_lat, n_cons, ed, em, to);
        checks++; if (lat != 17) begin errors++; $display("FAIL inv_latency: got %0d want 17", lat); end
        checks++; if (data_o !== 128'h0) begin errors++; $display("FAIL inv_data: got %h want 0", data_o); end
        @(negedge clk_i);
        checks++; if (out_req_o !== 1'b1) begin errors++; $display("FAIL inv_req_held: got %b want 1", out_req_o); end
        out_ack_i = 1'b1; en_i = 1'b0;
        @(posedge clk_i);
        #1 out_ack_i = 1'b0;
        @(negedge clk_i);
        checks++; if (out_req_o !== 1'b0) begin errors++; $display("FAIL inv_ack_req: got %b want 0", out_req_o); end
        checks++; if (mask_o !== 128'h0) begin errors++; $display("FAIL inv_ack_mask: got %h want 0", mask_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL inv_ack_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_stalls;
        int lat, exp_lat, n_cons;
        logic [127:0] d, m, ed, em;
        bit to;
        d = rand128(); m = rand128();
        run_op(d, m, 2'b01, 1, 0, 18'h0, 0, 0, lat, exp_lat, n_cons, ed, em, to);
        checks++; if (lat != 33) begin errors++; $display("FAIL stall_latency: got %0d want 33", lat); end
        checks++; if (n_cons != 16) begin errors++; $display("FAIL stall_consumes: got %0d want 16", n_cons); end
        checks++; if (data_o !== ed) begin errors++; $display("FAIL stall_data: got %h want %h", data_o, ed); end
        checks++; if (mask_o !== em) begin errors++; $display("FAIL stall_mask: got %h want %h", mask_o, em); end
        @(negedge clk_i);
        out_ack_i = 1'b1; en_i = 1'b0;
        @(posedge clk_i);
        #1 out_ack_i = 1'b0;
        @(negedge clk_i);
        checks++; if (data_o !== 128'h0) begin errors++; $display("FAIL stall_ack_data: got %h want 0", data_o); end
        checks++; if (mask_o !== 128'h0) begin errors++; $display("FAIL stall_ack_mask: got %h want 0", mask_o); end
    endtask

    task automatic test_abort;
        int lat, exp_lat, n_cons, req_seen;
        logic [127:0] ed, em;
        bit to;
        run_op(rand128(), rand128(), 2'b01, 0, 0, 18'h0, 5, 0, lat, exp_lat, n_cons, ed, em, to);
        @(negedge clk_i);
        checks++; if (n_cons != 5) begin errors++; $display("FAIL abort_consumes: got %0d want 5", n_cons); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy_o); end
        checks++; if (data_o !== 128'h0) begin errors++; $display("FAIL abort_data: got %h want 0", data_o); end
        checks++; if (mask_o !== 128'h0) begin errors++; $display("FAIL abort_mask: got %h want 0", mask_o); end
        req_seen = 0;
        prd_valid_i = 1'b1;
        repeat (20) begin
            @(negedge clk_i);
            if (out_req_o) req_seen++;
        end
        prd_valid_i = 1'b0;
        checks++; if (req_seen != 0) begin errors++; $display("FAIL abort_no_req: got %0d want 0", req_seen); end
    endtask

    task automatic test_reject;
        logic [1:0] bad;
        for (int k = 0; k < 2; k++) begin
            int err_pulses, busy_seen;
            bad = (k == 0) ? 2'b11 : 2'b00;
            @(negedge clk_i);
            en_i = 1'b1; op_i = bad;
            @(posedge clk_i);
            #1 en_i = 1'b0;
            err_pulses = 0; busy_seen = 0;
            repeat (5) begin
                @(negedge clk_i);
                if (err_o) err_pulses++;
                if (busy_o) busy_seen++;
            end
            checks++; if (err_pulses != 1) begin errors++; $display("FAIL reject_err_%b: got %0d pulses want 1", bad, err_pulses); end
            checks++; if (busy_seen != 0) begin errors++; $display("FAIL reject_busy_%b: got %0d busy cycles want 0", bad, busy_seen); end
        end
    endtask

    task automatic test_reset_mid_run;
        int lat, exp_lat, n_cons;
        logic [127:0] ed, em;
        bit to;
        run_op(rand128(), rand128(), 2'b10, 0, 0, 18'h0, 8, 1, lat, exp_lat, n_cons, ed, em, to);
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy_o); end
        checks++; if (data_o !== 128'h0) begin errors++; $display("FAIL rst_mid_data: got %h want 0", data_o); end
        checks++; if (mask_o !== 128'h0) begin errors++; $display("FAIL rst_mid_mask: got %h want 0", mask_o); end
        checks++; if (out_req_o !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %b want 0", out_req_o); end
        run_op(rand128(), rand128(), 2'b01, 0, 0, 18'h0, 0, 0, lat, exp_lat, n_cons, ed, em, to);
        checks++; if (lat != 17) begin errors++; $display("FAIL rst_restart_latency: got %0d want 17", lat); end
        checks++; if (data_o !== ed) begin errors++; $display("FAIL rst_restart_data: got %h want %h", data_o, ed); end
        checks++; if (mask_o !== em) begin errors++; $display("FAIL rst_restart_mask: got %h want %h", mask_o, em); end
        release_op();
    endtask

    task automatic test_random;
        for (int it = 0; it < 6; it++) begin
            int lat, exp_lat, n_cons;
            logic [127:0] ed, em;
            logic [1:0] op;
            bit to;
            op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            run_op(rand128(), rand128(), op, 2, 0, 18'h0, 0, 0, lat, exp_lat, n_cons, ed, em, to);
            checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout: out_req not seen within budget", it); end
            checks++; if (lat != exp_lat) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", it, lat, exp_lat); end
            checks++; if (n_cons != 16) begin errors++; $display("FAIL rand%0d_consumes: got %0d want 16", it, n_cons); end
            checks++; if (data_o !== ed) begin errors++; $display("FAIL rand%0d_data: got %h want %h", it, data_o, ed); end
            checks++; if (mask_o !== em) begin errors++; $display("FAIL rand%0d_mask: got %h want %h", it, mask_o, em); end
            release_op();
        end
    endtask

    initial begin
        rst_ni = 1'b0; en_i = 1'b0; op_i = 2'b00; data_i = '0; mask_i = '0;
        prd_i = '0; prd_valid_i = 1'b0; out_ack_i = 1'b0;
        build_tables();
        test_reset();
        test_zero_state();
        test_masked_fwd();
        test_inverse_ack();
        test_stalls();
        test_abort();
        test_reject();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
